// File: rtl/sm3_inpt_arb.sv
// Two-requester, message-granular round-robin arbiter in front of one SM3 core.
// Grants are held for a whole message; results are routed back in grant order.
module sm3_inpt_arb #(
  parameter int INPT_DW    = 32,
  parameter int ORDR_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_vld,
  input  logic [2*INPT_DW-1:0]       req_d,
  input  logic [1:0]                 req_lst,
  input  logic [2*(INPT_DW/8)-1:0]   req_vld_byte,
  output logic [1:0]                 req_rdy,
  output logic                       core_inpt_vld,
  output logic [INPT_DW-1:0]         core_inpt_d,
  output logic                       core_inpt_lst,
  output logic [INPT_DW/8-1:0]       core_inpt_vld_byte,
  input  logic                       core_inpt_rdy,
  input  logic [255:0]               core_res,
  input  logic                       core_res_vld,
  output logic [255:0]               res,
  output logic [1:0]                 res_vld,
  output logic                       busy,
  output logic                       err_orphan
);

  localparam int BW = INPT_DW / 8;
  localparam int AW = $clog2(ORDR_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(ORDR_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRNT0 = 2'd1;
  localparam logic [1:0] ST_GRNT1 = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  rr_last_q, rr_last_d;
  logic [ORDR_DEPTH-1:0] own_q;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           cnt_q, cnt_d;
  logic [255:0]          res_q;
  logic [1:0]            res_vld_q, res_vld_d;
  logic                  err_orphan_q;

  logic gnt_act_s;
  logic sel_s;
  logic xfer_s;
  logic push_s;
  logic pop_s;
  logic head_s;

  // decode which requester (if any) currently owns the core input
  always_comb begin
    case (state_q)
      ST_GRNT0: begin
        gnt_act_s = 1'b1;
        sel_s     = 1'b0;
      end
      ST_GRNT1: begin
        gnt_act_s = 1'b1;
        sel_s     = 1'b1;
      end
      default: begin
        gnt_act_s = 1'b0;
        sel_s     = 1'b0;
      end
    endcase
  end

  // combinational pass-through of the granted requester to the core
  always_comb begin
    if (gnt_act_s) begin
      core_inpt_vld      = req_vld[sel_s];
      core_inpt_d        = sel_s ? req_d[2*INPT_DW-1:INPT_DW] : req_d[INPT_DW-1:0];
      core_inpt_lst      = req_lst[sel_s];
      core_inpt_vld_byte = sel_s ? req_vld_byte[2*BW-1:BW] : req_vld_byte[BW-1:0];
      req_rdy            = sel_s ? {core_inpt_rdy, 1'b0} : {1'b0, core_inpt_rdy};
    end else begin
      core_inpt_vld      = 1'b0;
      core_inpt_d        = '0;
      core_inpt_lst      = 1'b0;
      core_inpt_vld_byte = '0;
      req_rdy            = 2'b00;
    end
  end

  assign xfer_s = core_inpt_vld & core_inpt_rdy;
  assign push_s = xfer_s & core_inpt_lst;
  assign pop_s  = core_res_vld & (cnt_q != '0);
  assign head_s = own_q[rd_ptr_q];

  // grant FSM and round-robin pointer
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    case (state_q)
      ST_IDLE: begin
        if ((req_vld != 2'b00) && (cnt_q < DEPTH_C)) begin
          if (req_vld == 2'b11) begin
            state_d = rr_last_q ? ST_GRNT0 : ST_GRNT1;
          end else begin
            state_d = req_vld[1] ? ST_GRNT1 : ST_GRNT0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRNT0, ST_GRNT1: begin
        if (push_s) begin
          state_d   = ST_IDLE;
          rr_last_d = sel_s;
        end else begin
          state_d   = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ownership FIFO occupancy and result-valid steering
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (pop_s) begin
      res_vld_d = head_s ? 2'b10 : 2'b01;
    end else begin
      res_vld_d = 2'b00;
    end
  end

  // state, FIFO and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= 1'b1;
      own_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      res_vld_q    <= 2'b00;
      err_orphan_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      res_vld_q <= res_vld_d;
      if (push_s) begin
        own_q[wr_ptr_q] <= sel_s;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        res_q    <= core_res;
      end
      // an unmatched result is a protocol error that only reset clears
      if (core_res_vld && (cnt_q == '0)) begin
        err_orphan_q <= 1'b1;
      end
    end
  end

  assign res        = res_q;
  assign res_vld    = res_vld_q;
  assign err_orphan = err_orphan_q;
  assign busy       = (state_q != ST_IDLE) | (cnt_q != '0);

endmodule

// File: tb/tb_sm3_inpt_arb.sv
// Directed bench for sm3_inpt_arb: grant sequencing, message locking, FIFO
// full/wrap, orphan results and asynchronous reset mid-message.
module tb_sm3_inpt_arb;

  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam logic [255:0] ABC_HASH =
    256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_vld;
  logic [2*DW-1:0]   req_d;
  logic [1:0]        req_lst;
  logic [2*BW-1:0]   req_vld_byte;
  logic [1:0]        req_rdy;
  logic              core_inpt_vld;
  logic [DW-1:0]     core_inpt_d;
  logic              core_inpt_lst;
  logic [BW-1:0]     core_inpt_vld_byte;
  logic              core_inpt_rdy;
  logic [255:0]      core_res;
  logic              core_res_vld;
  logic [255:0]      res;
  logic [1:0]        res_vld;
  logic              busy;
  logic              err_orphan;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sm3_inpt_arb #(.INPT_DW(DW), .ORDR_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_d(req_d), .req_lst(req_lst), .req_vld_byte(req_vld_byte),
    .req_rdy(req_rdy),
    .core_inpt_vld(core_inpt_vld), .core_inpt_d(core_inpt_d), .core_inpt_lst(core_inpt_lst),
    .core_inpt_vld_byte(core_inpt_vld_byte), .core_inpt_rdy(core_inpt_rdy),
    .core_res(core_res), .core_res_vld(core_res_vld),
    .res(res), .res_vld(res_vld), .busy(busy), .err_orphan(err_orphan)
  );

  task automatic chk_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    req_vld       = 2'b00;
    req_d         = '0;
    req_lst       = 2'b00;
    req_vld_byte  = '0;
    core_inpt_rdy = 1'b0;
    core_res      = '0;
    core_res_vld  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   wc[2];
    int   msg_n, xfers, words, gap_left;
    logic own, saw_r1, done;
    logic [1:0] exp_rv [3];

    // reset state
    do_reset();
    #1;
    chk_eq("rst_rdy", req_rdy, 2'b00);
    chk_eq("rst_cvld", core_inpt_vld, 1'b0);
    chk_eq("rst_rvld", res_vld, 2'b00);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_orph", err_orphan, 1'b0);

    // single "abc" word from requester 0
    req_vld = 2'b01;
    req_d[DW-1:0] = 32'h6162_6300;
    req_lst = 2'b01;
    req_vld_byte[BW-1:0] = 4'b1110;
    core_inpt_rdy = 1'b1;
    #1;
    chk_eq("abc_idle_rdy", req_rdy, 2'b00);
    chk_eq("abc_idle_vld", core_inpt_vld, 1'b0);
    cyc(); #1;
    chk_eq("abc_vld", core_inpt_vld, 1'b1);
    chk_eq("abc_d", core_inpt_d, 32'h6162_6300);
    chk_eq("abc_lst", core_inpt_lst, 1'b1);
    chk_eq("abc_be", core_inpt_vld_byte, 4'b1110);
    chk_eq("abc_rdy", req_rdy, 2'b01);
    cyc();
    req_vld = 2'b00;
    #1;
    chk_eq("abc_busy_q", busy, 1'b1);
    chk_eq("abc_back_idle", core_inpt_vld, 1'b0);
    core_res = ABC_HASH;
    core_res_vld = 1'b1;
    cyc();
    core_res_vld = 1'b0;
    #1;
    chk_eq("abc_rvld", res_vld, 2'b01);
    chk_eq("abc_res", res, ABC_HASH);
    chk_eq("abc_busy_done", busy, 1'b0);
    cyc(); #1;
    chk_eq("abc_rvld_pulse", res_vld, 2'b00);
    chk_eq("abc_res_hold", res, ABC_HASH);

    // both requesters streaming 16-word messages: strict alternation
    do_reset();
    req_vld = 2'b11;
    req_vld_byte = '1;
    core_inpt_rdy = 1'b1;
    wc = '{0, 0};
    msg_n = 0;
    for (int c = 0; c < 150 && msg_n < 4; c++) begin
      for (int r = 0; r < 2; r++) begin
        req_d[r*DW +: DW] = 32'hA000_0000 + 32'(r << 24) + 32'(wc[r]);
        req_lst[r] = (wc[r] == 15);
      end
      #1;
      if (core_inpt_vld && core_inpt_rdy) begin
        own = msg_n[0];
        chk_eq("alt_own", req_rdy, own ? 2'b10 : 2'b01);
        chk_eq("alt_word", core_inpt_d, 32'hA000_0000 + 32'(int'(own) << 24) + 32'(wc[own]));
        chk_eq("alt_lst", core_inpt_lst, wc[own] == 15);
        if (wc[own] == 15) begin
          wc[own] = 0;
          msg_n++;
        end else begin
          wc[own]++;
        end
      end
      cyc();
    end
    req_vld = 2'b00;
    chk_eq("alt_msgs", msg_n, 4);
    for (int k = 0; k < 4; k++) begin
      core_res = {8{32'hC0DE_0000 + 32'(k)}};
      core_res_vld = 1'b1;
      cyc();
      core_res_vld = 1'b0;
      #1;
      chk_eq("alt_res_vld", res_vld, k[0] ? 2'b10 : 2'b01);
      chk_eq("alt_res", res, {8{32'hC0DE_0000 + 32'(k)}});
    end
    chk_eq("alt_busy_done", busy, 1'b0);

    // random core back-pressure plus a 5-cycle owner gap mid-message
    do_reset();
    req_vld_byte = '1;
    req_d[DW +: DW] = 32'hDEAD_BEEF;
    req_lst[1] = 1'b1;
    wc[0] = 0;
    words = 0;
    gap_left = 5;
    saw_r1 = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      core_inpt_rdy = 1'($urandom_range(0, 1));
      if (wc[0] == 7 && gap_left > 0) begin
        req_vld = 2'b10;
        gap_left--;
      end else begin
        req_vld = 2'b11;
      end
      req_d[DW-1:0] = 32'hB000_0000 + 32'(wc[0]);
      req_lst[0] = (wc[0] == 15);
      #1;
      if (req_rdy[1]) saw_r1 = 1'b1;
      if (core_inpt_vld && core_inpt_rdy) begin
        chk_eq("gap_word", core_inpt_d, 32'hB000_0000 + 32'(wc[0]));
        words++;
        if (core_inpt_lst) done = 1'b1;
        wc[0]++;
      end
      cyc();
    end
    req_vld = 2'b00;
    chk_eq("gap_done", done, 1'b1);
    chk_eq("gap_words", words, 16);
    chk_eq("gap_other_rdy", saw_r1, 1'b0);

    // ownership FIFO full, release, same-cycle push/pop and wrap-around
    do_reset();
    req_vld = 2'b11;
    req_lst = 2'b11;
    req_vld_byte = '1;
    core_inpt_rdy = 1'b1;
    req_d = {32'h1111_1111, 32'h0000_0000};
    xfers = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (core_inpt_vld && core_inpt_rdy) begin
        chk_eq("full_own", req_rdy, xfers[0] ? 2'b10 : 2'b01);
        xfers++;
      end
      cyc();
    end
    #1;
    chk_eq("full_xfers", xfers, 4);
    chk_eq("full_stall_vld", core_inpt_vld, 1'b0);
    chk_eq("full_stall_rdy", req_rdy, 2'b00);
    chk_eq("full_busy", busy, 1'b1);
    core_res = {8{32'h5151_0001}};
    core_res_vld = 1'b1;
    cyc();
    core_res_vld = 1'b0;
    #1;
    chk_eq("full_r1_vld", res_vld, 2'b01);
    chk_eq("full_r1_nogrant", core_inpt_vld, 1'b0);
    cyc(); #1;
    chk_eq("full_5th_rdy", req_rdy, 2'b01);
    chk_eq("full_5th_vld", core_inpt_vld, 1'b1);
    core_res = {8{32'h5151_0002}};
    core_res_vld = 1'b1;
    cyc();
    core_res_vld = 1'b0;
    req_vld = 2'b00;
    #1;
    chk_eq("full_r2_vld", res_vld, 2'b10);
    chk_eq("full_r2_res", res, {8{32'h5151_0002}});
    chk_eq("full_r2_busy", busy, 1'b1);
    exp_rv = '{2'b01, 2'b10, 2'b01};
    for (int k = 0; k < 3; k++) begin
      core_res = {8{32'h5151_0003 + 32'(k)}};
      core_res_vld = 1'b1;
      cyc();
      core_res_vld = 1'b0;
      #1;
      chk_eq("full_drain_vld", res_vld, exp_rv[k]);
    end
    chk_eq("full_drain_busy", busy, 1'b0);

    // result with nothing outstanding
    core_res = {8{32'hBAD0_BAD0}};
    core_res_vld = 1'b1;
    cyc();
    core_res_vld = 1'b0;
    #1;
    chk_eq("orph_rvld", res_vld, 2'b00);
    chk_eq("orph_flag", err_orphan, 1'b1);
    chk_eq("orph_busy", busy, 1'b0);
    repeat (3) cyc();
    #1;
    chk_eq("orph_sticky", err_orphan, 1'b1);

    // three single-word messages from requester 0, one result returned
    req_vld = 2'b01;
    req_lst = 2'b01;
    req_d = {32'h0, 32'h3333_0000};
    xfers = 0;
    for (int c = 0; c < 20 && xfers < 3; c++) begin
      #1;
      if (core_inpt_vld && core_inpt_rdy) xfers++;
      cyc();
    end
    req_vld = 2'b00;
    chk_eq("mid_pend_xfers", xfers, 3);
    core_res = {8{32'h9999_0001}};
    core_res_vld = 1'b1;
    cyc();
    core_res_vld = 1'b0;
    #1;
    chk_eq("mid_pop_vld", res_vld, 2'b01);
    // 7 words of a 16-word message from requester 1, then reset
    req_vld = 2'b10;
    req_lst = 2'b00;
    xfers = 0;
    for (int c = 0; c < 40 && xfers < 7; c++) begin
      req_d[DW +: DW] = 32'h7777_0000 + 32'(xfers);
      #1;
      if (core_inpt_vld && core_inpt_rdy) xfers++;
      cyc();
    end
    chk_eq("mid_words", xfers, 7);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_cvld", core_inpt_vld, 1'b0);
    chk_eq("mid_rst_cd", core_inpt_d, 32'h0);
    chk_eq("mid_rst_be", core_inpt_vld_byte, 4'b0000);
    chk_eq("mid_rst_rdy", req_rdy, 2'b00);
    chk_eq("mid_rst_rvld", res_vld, 2'b00);
    chk_eq("mid_rst_res", res, 256'h0);
    chk_eq("mid_rst_busy", busy, 1'b0);
    chk_eq("mid_rst_orph", err_orphan, 1'b0);
    req_vld = 2'b11;
    req_lst = 2'b11;
    cyc();
    rst_n = 1'b1;
    #1;
    chk_eq("post_rst_idle", req_rdy, 2'b00);
    cyc(); #1;
    chk_eq("post_rst_tie", req_rdy, 2'b01);
    chk_eq("post_rst_vld", core_inpt_vld, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sm3_inpt_arb.md
Name: sm3_inpt_arb

Overview:
- Two-requester, message-granular round-robin arbiter sharing one SM3 core input port (padding + compression).
- Locks the grant from the first word to the last word of a message, so messages are never interleaved on the core.
- Records the owner of each granted message in an in-order ownership FIFO and routes each returned 256-bit hash to that owner.
- Sits between the host-side message sources and the sm3 core's input and result ports.

Parameters:
- INPT_DW, 32, message word width; 32 or 64, matching SM3_INPT_DW_32 / SM3_INPT_DW_64.
- ORDR_DEPTH, 4, ownership FIFO depth: maximum number of messages in flight inside the core (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  2  per-requester word valid
- req_d  in  2*INPT_DW  per-requester word; requester i occupies bits [i*INPT_DW +: INPT_DW]
- req_lst  in  2  per-requester last word of message
- req_vld_byte  in  2*(INPT_DW/8)  per-requester byte enables, meaningful on the last word only
- req_rdy  out  2  per-requester ready
- core_inpt_vld  out  1  word valid to core
- core_inpt_d  out  INPT_DW  word to core
- core_inpt_lst  out  1  last word to core
- core_inpt_vld_byte  out  INPT_DW/8  byte enables to core
- core_inpt_rdy  in  1  core ready
- core_res  in  256  hash result from core
- core_res_vld  in  1  result valid (single-cycle pulse)
- res  out  256  routed result
- res_vld  out  2  per-requester result valid
- busy  out  1  a grant is active, or the ownership FIFO is non-empty
- err_orphan  out  1  sticky: result arrived with the ownership FIFO empty

Behaviour:
- Reset: all outputs 0; state IDLE; rr_last=1 (requester 0 wins the first tie); FIFO empty; err_orphan=0. Reset mid-message aborts the message and discards FIFO contents; no flush handshake.
- State machine: IDLE, GRNT0, GRNT1.
  - IDLE → GRNTi when any req_vld is set and FIFO count < ORDR_DEPTH.
  - If both requesters are valid, pick i != rr_last; if only one is valid, pick it.
  - Grant is registered: the grant decision takes 1 cycle; the first word passes in the following cycle at the earliest.
  - In IDLE, req_rdy = 0 and core_inpt_vld = 0.
- In GRNTi the input path is combinational pass-through:
  - core_inpt_vld = req_vld[i]; core_inpt_d, core_inpt_lst and core_inpt_vld_byte are muxed from requester i.
  - req_rdy[i] = core_inpt_rdy; the other req_rdy = 0.
  - A word transfers when core_inpt_vld and core_inpt_rdy are both high.
  - On transfer of a word with core_inpt_lst=1: push i into the FIFO, set rr_last=i, go to IDLE in the next cycle.
  - Dropping req_vld mid-message keeps the grant; no timeout.
- Result routing:
  - On core_res_vld: res = core_res registered; res_vld[head] = 1 for exactly one cycle (1-cycle latency); pop the FIFO.
  - res holds its value until the next result.
  - If the FIFO is empty when core_res_vld arrives: no res_vld, no pop, err_orphan set until reset.
- FIFO boundaries:
  - Push and pop in the same cycle: count unchanged, order preserved; pointers wrap modulo ORDR_DEPTH.
  - No new grant while count == ORDR_DEPTH. An active grant was issued with count < DEPTH, so a push can never overflow.
- busy = (state != IDLE) | (count != 0).
- Single-word message (first word has lst=1): legal; granted, pushed, back to IDLE, i.e. 2 cycles per message minimum.

Test Plan:
- Requester 0 only, "abc" (1 word, 0x61626300, vld_byte=4'b1110, lst=1), core_rdy=1 → word on the core 1 cycle after the grant; FIFO holds {0}. Core returns 66c7f0f4...8f4ba8e0 → res_vld=2'b01 for 1 cycle, res matches, busy drops to 0.
- Both requesters valid continuously with 16-word messages → grants alternate 0,1,0,1; no interleaving (core_inpt_lst precedes every switch); results return to 0,1,0,1 in order.
- core_inpt_rdy toggled randomly plus a 5-cycle req_vld gap mid-message by the owner → grant held, other requester sees req_rdy=0 throughout, word count into the core = 16.
- Core withholds results; 5 single-word messages requested → 4 granted; the 5th waits while busy=1. Release one result → same-cycle pop; 5th granted next IDLE cycle; order preserved across wrap-around.
- core_res_vld pulsed with FIFO empty → res_vld=0, err_orphan=1 and held until rst_n low.
- rst_n asserted after 7 words of a 16-word message with 2 results pending → all outputs 0 immediately; after release, requester 0 wins a simultaneous request.
